inst_fetch_queue: RTL

//  Instruction-fetch front end; consumes the PC from the PC-generator (simpleBranch) and issues requests to instruction memory.

---
 rtl/inst_fetch_queue_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/inst_fetch_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared fetch defaults: address/instruction widths and reset PC
package inst_fetch_queue_pkg;

    localparam int DEF_ADDR_SIZE = 32;
    localparam int DEF_INST_SIZE = 32;

    // Must match the reset value of the PC generator feeding pc_in.
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with push/pop/clear, occupancy count and async reset
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Explicit wrap keeps non-power-of-2 depths (e.g. MAX_OUTST=3) correct.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !clear && count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && !clear && count == '0));

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch front end: issue credit, PC tagging, flush drop and decode queue
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int INST_SIZE   = DEF_INST_SIZE,
    parameter int QUEUE_DEPTH = 4,
    parameter int MAX_OUTST   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] pc_in,
    input  logic                 flush,
    output logic                 pc_stall,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [ADDR_SIZE-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [INST_SIZE-1:0] imem_rsp_data,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [INST_SIZE-1:0] inst_data,
    output logic [ADDR_SIZE-1:0] inst_pc
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int QW = $clog2(QUEUE_DEPTH + 1);
    localparam int EW = ADDR_SIZE + INST_SIZE;

    logic [OW-1:0]        live_cnt;
    logic [OW-1:0]        drop_cnt;
    logic [QW-1:0]        q_count;
    logic [OW-1:0]        pc_count;
    logic [ADDR_SIZE-1:0] pc_head;
    logic [EW-1:0]        q_head;
    logic                 outst_ok;
    logic                 queue_ok;
    logic                 fire;
    logic                 rsp_keep;
    logic                 rsp_drop;
    logic                 q_pop;

    // Live requests reserve queue slots, so a kept response always has room.
    assign outst_ok = (32'(live_cnt) + 32'(drop_cnt)) < $unsigned(MAX_OUTST);
    assign queue_ok = (32'(live_cnt) + 32'(q_count)) < $unsigned(QUEUE_DEPTH);

    assign imem_req_valid = !reset && !flush && outst_ok && queue_ok;
    assign imem_req_addr  = pc_in;
    assign fire           = imem_req_valid && imem_req_ready;
    assign pc_stall       = reset || (!fire && !flush);

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !flush;
    assign q_pop    = inst_valid && inst_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_cnt <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            live_cnt <= '0;
            drop_cnt <= live_cnt + drop_cnt - OW'(imem_rsp_valid);
        end else begin
            live_cnt <= live_cnt + OW'(fire) - OW'(rsp_keep);
            drop_cnt <= drop_cnt - OW'(rsp_drop);
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_SIZE),
        .DEPTH (MAX_OUTST)
    ) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fire),
        .push_data (pc_in),
        .pop       (rsp_keep),
        .clear     (flush),
        .head      (pc_head),
        .count     (pc_count)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_keep),
        .push_data ({pc_head, imem_rsp_data}),
        .pop       (q_pop),
        .clear     (flush),
        .head      (q_head),
        .count     (q_count)
    );

    assign inst_valid = (q_count != '0);
    assign inst_pc    = q_head[EW-1:INST_SIZE];
    assign inst_data  = q_head[INST_SIZE-1:0];

    a_queue_room: assert property (@(posedge clk) disable iff (reset)
        !(rsp_keep && !q_pop && q_count == QW'(QUEUE_DEPTH)));
    a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && live_cnt == '0 && drop_cnt == '0));
    a_pc_tags_live: assert property (@(posedge clk) disable iff (reset)
        pc_count == live_cnt);

endmodule
